// File: rtl/register_file_nbit.sv
// DEPTH x WIDTH register file: two combinational read ports, one write port and an
// in-place INC/DEC/CLR port whose result drives registered carry/zero flags.
module register_file_nbit #(
  parameter int unsigned      WIDTH     = 8,
  parameter int unsigned      DEPTH     = 4,
  parameter int unsigned      ADDR_W    = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter bit               BYPASS    = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  input  logic [1:0]        op_i,
  input  logic [ADDR_W-1:0] opaddr_i,
  input  logic [ADDR_W-1:0] raddr_a_i,
  output logic [WIDTH-1:0]  rdata_a_o,
  input  logic [ADDR_W-1:0] raddr_b_i,
  output logic [WIDTH-1:0]  rdata_b_o,
  output logic              flag_c_o,
  output logic              flag_z_o
);

  typedef enum logic [1:0] {
    OpNop = 2'b00,
    OpInc = 2'b01,
    OpDec = 2'b10,
    OpClr = 2'b11
  } op_e;

  op_e op;
  assign op = op_e'(op_i);

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];
  logic             flag_c_q, flag_c_d;
  logic             flag_z_q, flag_z_d;

  logic w_valid, op_valid, op_hit;
  logic ra_valid, rb_valid;

  // Addresses past DEPTH only exist when DEPTH is not a power of two.
  assign w_valid  = we_i && (32'(waddr_i) < DEPTH);
  assign op_valid = (op != OpNop) && (32'(opaddr_i) < DEPTH);
  assign ra_valid = 32'(raddr_a_i) < DEPTH;
  assign rb_valid = 32'(raddr_b_i) < DEPTH;
  // A write to the same register takes priority; the op and its flag update are dropped.
  assign op_hit   = op_valid && !(we_i && (waddr_i == opaddr_i));

  logic [WIDTH-1:0] op_cur, op_res;
  logic             op_carry;

  always_comb begin
    op_cur   = op_valid ? regs_q[opaddr_i] : '0;
    op_res   = op_cur;
    op_carry = 1'b0;
    unique case (op)
      OpInc: begin
        op_res   = op_cur + WIDTH'(1);
        op_carry = &op_cur;
      end
      OpDec: begin
        op_res   = op_cur - WIDTH'(1);
        op_carry = ~|op_cur;
      end
      OpClr: begin
        op_res   = '0;
        op_carry = 1'b0;
      end
      default: ;
    endcase
  end

  always_comb begin
    regs_d   = regs_q;
    flag_c_d = flag_c_q;
    flag_z_d = flag_z_q;
    if (op_hit) begin
      regs_d[opaddr_i] = op_res;
      flag_c_d         = op_carry;
      flag_z_d         = ~|op_res;
    end
    if (w_valid) begin
      regs_d[waddr_i] = wdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        regs_q[i] <= RESET_VAL;
      end
      flag_c_q <= 1'b0;
      flag_z_q <= 1'b0;
    end else begin
      regs_q   <= regs_d;
      flag_c_q <= flag_c_d;
      flag_z_q <= flag_z_d;
    end
  end

  always_comb begin
    rdata_a_o = '0;
    if (ra_valid) begin
      rdata_a_o = regs_q[raddr_a_i];
      if (BYPASS && we_i && (raddr_a_i == waddr_i)) begin
        rdata_a_o = wdata_i;
      end
    end
  end

  always_comb begin
    rdata_b_o = '0;
    if (rb_valid) begin
      rdata_b_o = regs_q[raddr_b_i];
      if (BYPASS && we_i && (raddr_b_i == waddr_i)) begin
        rdata_b_o = wdata_i;
      end
    end
  end

  assign flag_c_o = flag_c_q;
  assign flag_z_o = flag_z_q;

endmodule

// File: tb/tb_register_file_nbit.sv
// Bench for register_file_nbit: a DEPTH=4/BYPASS=1 and a DEPTH=3/BYPASS=0 instance share
// stimulus; both are checked against an array model, dut0 also against a hand-written table.
module tb_register_file_nbit;

  logic       clk;
  logic       rst_n;
  logic       we;
  logic [1:0] waddr;
  logic [7:0] wdata;
  logic [1:0] op;
  logic [1:0] opaddr;
  logic [1:0] raddr_a;
  logic [1:0] raddr_b;
  logic [7:0] rda [2];
  logic [7:0] rdb [2];
  logic       fc  [2];
  logic       fz  [2];

  register_file_nbit #(
    .WIDTH(8), .DEPTH(4), .ADDR_W(2), .RESET_VAL(8'h00), .BYPASS(1'b1)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
    .op_i(op), .opaddr_i(opaddr), .raddr_a_i(raddr_a), .rdata_a_o(rda[0]),
    .raddr_b_i(raddr_b), .rdata_b_o(rdb[0]), .flag_c_o(fc[0]), .flag_z_o(fz[0])
  );

  register_file_nbit #(
    .WIDTH(8), .DEPTH(3), .ADDR_W(2), .RESET_VAL(8'h00), .BYPASS(1'b0)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
    .op_i(op), .opaddr_i(opaddr), .raddr_a_i(raddr_a), .rdata_a_o(rda[1]),
    .raddr_b_i(raddr_b), .rdata_b_o(rdb[1]), .flag_c_o(fc[1]), .flag_z_o(fz[1])
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: plain arrays per instance.
  int         dep [2] = '{4, 3};
  bit         byp [2] = '{1'b1, 1'b0};
  logic [7:0] mdl [2][4];
  logic       mc  [2];
  logic       mz  [2];

  typedef struct {
    logic       we;
    logic [1:0] wa;
    logic [7:0] wd;
    logic [1:0] op;
    logic [1:0] oa;
    logic [1:0] ra;
    logic [1:0] rb;
    logic [7:0] ea;
    logic [7:0] eb;
    logic       ec;
    logic       ez;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_rd(input int k, input logic [1:0] a);
    if (int'(a) >= dep[k]) return 8'h00;
    if (byp[k] && we && (a == waddr)) return wdata;
    return mdl[k][a];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 4; i++) mdl[k][i] = 8'h00;
      mc[k] = 1'b0;
      mz[k] = 1'b0;
    end
  endtask

  task automatic model_update();
    logic [7:0] old;
    int         v;
    if (!rst_n) return;
    for (int k = 0; k < 2; k++) begin
      if (op != 2'd0 && int'(opaddr) < dep[k] && !(we && waddr == opaddr)) begin
        old = mdl[k][opaddr];
        v   = 0;
        case (op)
          2'd1: begin v = int'(old) + 1; mc[k] = (v == 256); end
          2'd2: begin v = int'(old) - 1; mc[k] = (v < 0);    end
          default: begin v = 0; mc[k] = 1'b0; end
        endcase
        v = (v + 256) % 256;
        mdl[k][opaddr] = 8'(v);
        mz[k] = (v == 0);
      end
      if (we && int'(waddr) < dep[k]) mdl[k][waddr] = wdata;
    end
  endtask

  task automatic check_model();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("dut%0d rdata_a[%0d]", k, raddr_a), rda[k], exp_rd(k, raddr_a));
      chk($sformatf("dut%0d rdata_b[%0d]", k, raddr_b), rdb[k], exp_rd(k, raddr_b));
      chk($sformatf("dut%0d flag_c", k), {7'd0, fc[k]}, {7'd0, mc[k]});
      chk($sformatf("dut%0d flag_z", k), {7'd0, fz[k]}, {7'd0, mz[k]});
    end
  endtask

  // Called #1 after a negedge with inputs applied; returns at the next negedge.
  task automatic step();
    check_model();
    model_update();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic w, input logic [1:0] wa, input logic [7:0] wd,
                       input logic [1:0] o, input logic [1:0] oa,
                       input logic [1:0] ra, input logic [1:0] rb);
    we = w; waddr = wa; wdata = wd; op = o; opaddr = oa; raddr_a = ra; raddr_b = rb;
  endtask

  initial begin
    // Expected values for dut0 (DEPTH=4, BYPASS=1), sampled before each row's posedge.
    tbl[0]  = '{1'b1, 2'd2, 8'hA5, 2'd0, 2'd0, 2'd2, 2'd0, 8'hA5, 8'h00, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 2'd1, 8'hFE, 2'd0, 2'd0, 2'd2, 2'd1, 8'hA5, 8'hFE, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 2'd0, 8'h00, 2'd1, 2'd1, 2'd1, 2'd1, 8'hFE, 8'hFE, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 2'd0, 8'h00, 2'd1, 2'd1, 2'd1, 2'd3, 8'hFF, 8'h00, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 2'd0, 8'h00, 2'd2, 2'd1, 2'd1, 2'd2, 8'h00, 8'hA5, 1'b1, 1'b1};
    tbl[5]  = '{1'b1, 2'd0, 8'h10, 2'd0, 2'd0, 2'd1, 2'd0, 8'hFF, 8'h10, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 2'd0, 8'h33, 2'd1, 2'd0, 2'd0, 2'd1, 8'h33, 8'hFF, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, 2'd1, 8'h05, 2'd0, 2'd0, 2'd0, 2'd1, 8'h33, 8'h05, 1'b1, 1'b0};
    tbl[8]  = '{1'b1, 2'd0, 8'h33, 2'd1, 2'd1, 2'd0, 2'd1, 8'h33, 8'h05, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 2'd0, 8'h00, 2'd3, 2'd2, 2'd0, 2'd1, 8'h33, 8'h06, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 2'd0, 8'h00, 2'd0, 2'd0, 2'd2, 2'd1, 8'h00, 8'h06, 1'b0, 1'b1};
    tbl[11] = '{1'b1, 2'd3, 8'h77, 2'd0, 2'd0, 2'd3, 2'd2, 8'h77, 8'h00, 1'b0, 1'b1};
    tbl[12] = '{1'b0, 2'd0, 8'h00, 2'd2, 2'd3, 2'd3, 2'd3, 8'h77, 8'h77, 1'b0, 1'b1};
    tbl[13] = '{1'b0, 2'd0, 8'h00, 2'd0, 2'd0, 2'd3, 2'd0, 8'h76, 8'h33, 1'b0, 1'b0};

    rst_n = 1'b0;
    drive(1'b0, 2'd0, 8'h00, 2'd0, 2'd0, 2'd0, 2'd0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].op, tbl[i].oa, tbl[i].ra, tbl[i].rb);
      #1;
      chk($sformatf("row%0d rdata_a", i), rda[0], tbl[i].ea);
      chk($sformatf("row%0d rdata_b", i), rdb[0], tbl[i].eb);
      chk($sformatf("row%0d flag_c", i), {7'd0, fc[0]}, {7'd0, tbl[i].ec});
      chk($sformatf("row%0d flag_z", i), {7'd0, fz[0]}, {7'd0, tbl[i].ez});
      step();
    end

    // Asynchronous reset pulse mid-cycle, checked before the next posedge.
    drive(1'b0, 2'd0, 8'h00, 2'd0, 2'd0, 2'd0, 2'd0);
    #2;
    rst_n = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      raddr_a = 2'(i);
      raddr_b = 2'(3 - i);
      #1;
      check_model();
      chk($sformatf("async reset reg%0d", i), rda[0], 8'h00);
    end

    // Write and op presented while reset is held must be discarded.
    @(negedge clk);
    drive(1'b1, 2'd2, 8'h5A, 2'd1, 2'd0, 2'd2, 2'd0);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 2'd0, 8'h00, 2'd0, 2'd0, 2'd2, 2'd0);
    #1;
    chk("write under reset dut0", rda[0], 8'h00);
    chk("write under reset dut1", rda[1], 8'h00);
    chk("op under reset", rdb[0], 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 2'd2, 8'h5A, 2'd0, 2'd0, 2'd2, 2'd0);
    #1;
    step();
    drive(1'b0, 2'd0, 8'h00, 2'd0, 2'd0, 2'd2, 2'd0);
    #1;
    chk("first write after release dut0", rda[0], 8'h5A);
    chk("first write after release dut1", rda[1], 8'h5A);
    step();

    // Randomised traffic; data biased toward wrap boundaries.
    for (int n = 0; n < 400; n++) begin
      logic [7:0] d;
      case ($urandom_range(0, 7))
        0: d = 8'h00;
        1: d = 8'hFF;
        2: d = 8'hFE;
        3: d = 8'h01;
        default: d = 8'($urandom);
      endcase
      drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), d,
            2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
      #1;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
